// File: rtl/gcd_pkg.sv
// Shared types for the binary-GCD engine: FSM state and per-cycle step selection.
package gcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } gcd_state_e;

   typedef enum logic [2:0] {
      SHIFT_BOTH,
      SHIFT_A,
      SHIFT_B,
      SUB_A,
      SUB_B,
      FINISH
   } gcd_step_e;

endpackage

// File: rtl/gcd_step.sv
// One combinational binary-GCD step: picks the operation for the current A/B pair
// and produces the next operands, the k increment and the finish flag.
module gcd_step
   import gcd_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] a_next_c_o,
   output logic [WIDTH-1:0] b_next_c_o,
   output logic             k_inc_c_o,
   output logic             finish_c_o
);

   gcd_step_e step_c;

   // Priority order matters: termination first, then common factors of two.
   always_comb begin
      step_c = FINISH;
      if (a_i == '0 || b_i == '0 || a_i == b_i) begin
         step_c = FINISH;
      end else if (!a_i[0] && !b_i[0]) begin
         step_c = SHIFT_BOTH;
      end else if (!a_i[0]) begin
         step_c = SHIFT_A;
      end else if (!b_i[0]) begin
         step_c = SHIFT_B;
      end else if (a_i > b_i) begin
         step_c = SUB_A;
      end else begin
         step_c = SUB_B;
      end
   end

   always_comb begin
      a_next_c_o = a_i;
      b_next_c_o = b_i;
      k_inc_c_o  = 1'b0;
      finish_c_o = 1'b0;
      unique case (step_c)
         SHIFT_BOTH: begin
            a_next_c_o = a_i >> 1;
            b_next_c_o = b_i >> 1;
            k_inc_c_o  = 1'b1;
         end
         SHIFT_A:    a_next_c_o = a_i >> 1;
         SHIFT_B:    b_next_c_o = b_i >> 1;
         SUB_A:      a_next_c_o = (a_i - b_i) >> 1;
         SUB_B:      b_next_c_o = (b_i - a_i) >> 1;
         default:    finish_c_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/gcd_engine.sv
// Iterative binary-GCD engine with valid/ready handshakes, one step per cycle.
// Define GCD_CYCLE_COUNT_EN to add the saturating CALC-cycle counter and cycles port.
module gcd_engine
   import gcd_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(2*WIDTH+3)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
`ifdef GCD_CYCLE_COUNT_EN
   ,
   output logic [CNT_W-1:0] cycles
`endif
);

   localparam int unsigned K_W = $clog2(WIDTH);

   gcd_state_e       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [K_W-1:0]   k_q, k_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             in_ready_q, out_valid_q;

   logic [WIDTH-1:0] a_next_c, b_next_c;
   logic             k_inc_c, finish_c;

   gcd_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .a_i        (a_q),
      .b_i        (b_q),
      .a_next_c_o (a_next_c),
      .b_next_c_o (b_next_c),
      .k_inc_c_o  (k_inc_c),
      .finish_c_o (finish_c)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      k_d      = k_q;
      result_d = result_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a_in;
               b_d     = b_in;
               k_d     = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            if (finish_c) begin
               result_d = (a_q | b_q) << k_q;
               state_d  = DONE;
            end else begin
               a_d = a_next_c;
               b_d = b_next_c;
               k_d = k_q + K_W'(k_inc_c);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake flags are registered from the next state so they track state_q exactly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         k_q         <= '0;
         result_q    <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         k_q         <= k_d;
         result_q    <= result_d;
         in_ready_q  <= (state_d == IDLE);
         out_valid_q <= (state_d == DONE);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;

`ifdef GCD_CYCLE_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counts every cycle spent in CALC, including the finishing one; frozen in DONE.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE && in_valid) begin
         cnt_d = '0;
      end else if (state_q == CALC && cnt_q != '1) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cycles = cnt_q;
`endif

endmodule
